// File: rtl/stab_monitor_pkg.sv
// Shared types and helpers for the multi-channel settling monitor.
package stab_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MON  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Width able to hold the values 0..ticks inclusive.
  function automatic int tick_w(input int ticks);
    return (ticks < 1) ? 1 : $clog2(ticks + 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/stab_monitor_channel.sv
// One monitored channel: previous sample, match compare, saturating run counter, stable flag.
// With STAB_TOLERANCE_EN defined a match is |new - prev| <= TOL, otherwise exact equality.
module stab_monitor_channel
  import stab_monitor_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int CNT_W         = 10,
  parameter int STABLE_THRESH = 20,
  parameter int TOL           = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              capture,
  input  logic              compare,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] prev,
  output logic [CNT_W-1:0]  cnt,
  output logic              stable
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic             match;
  logic [CNT_W-1:0] cnt_inc;

`ifdef STAB_TOLERANCE_EN
  localparam logic [DATA_W:0] TOL_V = (DATA_W+1)'(TOL);
  logic [DATA_W:0] diff;

  // One extra bit keeps the magnitude free of wrap-around.
  always_comb begin
    if (data >= prev) diff = {1'b0, data} - {1'b0, prev};
    else              diff = {1'b0, prev} - {1'b0, data};
    match = (diff <= TOL_V);
  end
`else
  assign match = (data == prev);
`endif

  assign cnt_inc = CNT_W'(sat_inc(32'(cnt), CNT_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      prev   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (capture) begin
      prev   <= data;
      cnt    <= '0;
      stable <= 1'b0;
    end else if (compare) begin
      prev <= data;
      if (match) begin
        cnt    <= cnt_inc;
        stable <= (cnt_inc >= CNT_W'(STABLE_THRESH));
      end else begin
        cnt    <= '0;
        stable <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stab_monitor_multi.sv
// Multi-channel settling monitor: window FSM, tick counter and readout mux around NUM_CH channels.
// Optional macro STAB_TOLERANCE_EN enables tolerance-based matching in each channel.
module stab_monitor_multi
  import stab_monitor_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int DATA_W        = 32,
  parameter int CNT_W         = 10,
  parameter int STABLE_THRESH = 20,
  parameter int TIMEOUT_TICKS = 1000,
  parameter int TOL           = 0,
  localparam int SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_tick,
  input  logic                     start,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        stable,
  output logic                     all_stable,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  input  logic [SEL_W-1:0]         rd_sel,
  output logic [DATA_W-1:0]        rd_value,
  output logic [CNT_W-1:0]         rd_cnt
);

  localparam int TW = tick_w(TIMEOUT_TICKS);
  localparam logic [TW-1:0] TICK_MAX = TW'(TIMEOUT_TICKS);

  state_t          state, next_state;
  logic [TW-1:0]   tick_cnt;
  logic            capture, compare, close;
  logic [DATA_W-1:0] prev_arr [NUM_CH];
  logic [CNT_W-1:0]  cnt_arr  [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    stab_monitor_channel #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .STABLE_THRESH(STABLE_THRESH), .TOL(TOL)
    ) u_ch (
      .clk(clk), .reset(reset), .clear(start), .capture(capture), .compare(compare),
      .data(ch_data[k*DATA_W +: DATA_W]), .prev(prev_arr[k]), .cnt(cnt_arr[k]),
      .stable(stable[k])
    );
  end

  assign all_stable = &stable;
  assign busy       = (state == ARM) || (state == MON);

  // A closing MON cycle swallows any coincident tick so results freeze exactly at close.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    compare    = 1'b0;
    close      = 1'b0;
    if (start) begin
      next_state = ARM;
    end else begin
      case (state)
        ARM: if (sample_tick) begin
          capture    = 1'b1;
          next_state = MON;
        end
        MON: if (all_stable || (tick_cnt == TICK_MAX)) begin
          close      = 1'b1;
          next_state = DONE;
        end else if (sample_tick) begin
          compare = 1'b1;
        end
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state <= next_state;
      if (start) begin
        tick_cnt <= '0;
        done     <= 1'b0;
        timeout  <= 1'b0;
      end else begin
        if (capture)      tick_cnt <= TW'(1);
        else if (compare) tick_cnt <= tick_cnt + TW'(1);
        if (close) begin
          done    <= 1'b1;
          timeout <= ~all_stable;
        end
      end
    end
  end

  always_comb begin
    rd_value = '0;
    rd_cnt   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(rd_sel) == k) begin
        rd_value = prev_arr[k];
        rd_cnt   = cnt_arr[k];
      end
    end
  end

endmodule

// File: tb/tb_stab_monitor_multi.sv
// Directed bench for stab_monitor_multi: a vector table plus hand-written window sequences.
module tb_stab_monitor_multi;
  import stab_monitor_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sample_tick = 1'b0;
  logic         start = 1'b0;
  logic [127:0] ch_data = '0;
  logic [3:0]   stable;
  logic         all_stable, busy, done, timeout;
  logic [1:0]   rd_sel = 2'd0;
  logic [31:0]  rd_value;
  logic [9:0]   rd_cnt;

  logic         start_b = 1'b0;
  logic         tick_b = 1'b0;
  logic [23:0]  data_b = '0;
  logic [2:0]   stable_b;
  logic         all_stable_b, busy_b, done_b, timeout_b;
  logic [1:0]   sel_b = 2'd0;
  logic [7:0]   val_b;
  logic [2:0]   cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stab_monitor_multi #(
    .NUM_CH(4), .DATA_W(32), .CNT_W(10), .STABLE_THRESH(20), .TIMEOUT_TICKS(50), .TOL(2)
  ) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .start(start), .ch_data(ch_data),
    .stable(stable), .all_stable(all_stable), .busy(busy), .done(done), .timeout(timeout),
    .rd_sel(rd_sel), .rd_value(rd_value), .rd_cnt(rd_cnt)
  );

  stab_monitor_multi #(
    .NUM_CH(3), .DATA_W(8), .CNT_W(3), .STABLE_THRESH(5), .TIMEOUT_TICKS(100), .TOL(0)
  ) dut_b (
    .clk(clk), .reset(reset), .sample_tick(tick_b), .start(start_b), .ch_data(data_b),
    .stable(stable_b), .all_stable(all_stable_b), .busy(busy_b), .done(done_b),
    .timeout(timeout_b), .rd_sel(sel_b), .rd_value(val_b), .rd_cnt(cnt_b)
  );

  typedef struct {
    logic         st;
    logic         tk;
    logic [127:0] d;
    logic [1:0]   sel;
    logic [3:0]   e_stable;
    logic         e_busy;
    logic         e_done;
    logic [31:0]  e_val;
    logic [9:0]   e_cnt;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [127:0] pack4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic tk);
    start = st;
    sample_tick = tk;
    @(posedge clk);
    #1;
    start = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic step_b(input logic st, input logic tk);
    start_b = st;
    tick_b = tk;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    tick_b = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, pack4(5, 5, 5, 5), 2'd0, 4'h0, 1'b0, 1'b0, 32'h0, 10'd0};
    vecs[1] = '{1'b1, 1'b0, pack4(1, 2, 3, 4), 2'd1, 4'h0, 1'b1, 1'b0, 32'h0, 10'd0};
    vecs[2] = '{1'b0, 1'b1, pack4(1, 2, 3, 4), 2'd1, 4'h0, 1'b1, 1'b0, 32'h2, 10'd0};
    vecs[3] = '{1'b0, 1'b1, pack4(1, 2, 3, 4), 2'd1, 4'h0, 1'b1, 1'b0, 32'h2, 10'd1};
    vecs[4] = '{1'b0, 1'b0, pack4(1, 2, 3, 4), 2'd3, 4'h0, 1'b1, 1'b0, 32'h4, 10'd1};
    vecs[5] = '{1'b0, 1'b1, pack4(1, 9, 3, 4), 2'd1, 4'h0, 1'b1, 1'b0, 32'h9, 10'd0};
    vecs[6] = '{1'b0, 1'b1, pack4(1, 9, 3, 4), 2'd0, 4'h0, 1'b1, 1'b0, 32'h1, 10'd3};
    vecs[7] = '{1'b1, 1'b1, pack4(7, 7, 7, 7), 2'd0, 4'h0, 1'b1, 1'b0, 32'h1, 10'd0};
    vecs[8] = '{1'b0, 1'b1, pack4(7, 7, 7, 7), 2'd0, 4'h0, 1'b1, 1'b0, 32'h7, 10'd0};
    vecs[9] = '{1'b0, 1'b1, pack4(7, 7, 7, 7), 2'd2, 4'h0, 1'b1, 1'b0, 32'h7, 10'd1};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_stable", 32'(stable), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_val", rd_value, 32'h0);
    chk("rst_cnt", 32'(rd_cnt), 32'h0);

    // Vector table: IDLE tick ignored, arming, compares, start-vs-tick priority.
    for (int i = 0; i < 10; i++) begin
      ch_data = vecs[i].d;
      rd_sel  = vecs[i].sel;
      step(vecs[i].st, vecs[i].tk);
      chk($sformatf("vec%0d_stable", i), 32'(stable), 32'(vecs[i].e_stable));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      chk($sformatf("vec%0d_val", i), rd_value, vecs[i].e_val);
      chk($sformatf("vec%0d_cnt", i), 32'(rd_cnt), 32'(vecs[i].e_cnt));
    end

    // Constant data on all channels: stable after the 20th compare, window closes clean.
    rd_sel = 2'd0;
    ch_data = pack4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    chk("const_cnt19", 32'(rd_cnt), 32'd19);
    chk("const_stable_pre", 32'(stable), 32'h0);
    step(1'b0, 1'b1);
    chk("const_stable", 32'(stable), 32'hF);
    chk("const_all", 32'(all_stable), 32'h1);
    chk("const_done_pre", 32'(done), 32'h0);
    step(1'b0, 1'b0);
    chk("const_done", 32'(done), 32'h1);
    chk("const_timeout", 32'(timeout), 32'h0);
    chk("const_busy", 32'(busy), 32'h0);
    rd_sel = 2'd1;
    ch_data = pack4(32'h1, 32'h2, 32'h3, 32'h4);
    step(1'b0, 1'b1);
    chk("frozen_val", rd_value, 32'h3F800000);
    chk("frozen_cnt", 32'(rd_cnt), 32'd20);
    chk("frozen_done", 32'(done), 32'h1);

    // Channel 2 toggles: window runs to the 50-tick timeout.
    step(1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      ch_data = pack4(32'hA5, 32'hA5, (i % 2 == 1) ? 32'h100 : 32'h0, 32'hA5);
      step(1'b0, 1'b1);
    end
    chk("tmo_done_pre", 32'(done), 32'h0);
    chk("tmo_busy_pre", 32'(busy), 32'h1);
    ch_data = pack4(32'hA5, 32'hA5, 32'h777, 32'hA5);
    step(1'b0, 1'b1);
    chk("tmo_done", 32'(done), 32'h1);
    chk("tmo_timeout", 32'(timeout), 32'h1);
    chk("tmo_stable", 32'(stable), 32'hB);
    rd_sel = 2'd2;
    #1;
    chk("tmo_cnt2", 32'(rd_cnt), 32'd0);
    chk("tmo_val2", rd_value, 32'h100);
    rd_sel = 2'd0;
    #1;
    chk("tmo_cnt0", 32'(rd_cnt), 32'd49);

    // All channels become stable on exactly the last allowed tick: timeout stays low.
    step(1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      ch_data = pack4(32'hC3, 32'hC3,
                      (i >= 29) ? 32'h200 : ((i % 2 == 1) ? 32'h100 : 32'h0), 32'hC3);
      step(1'b0, 1'b1);
    end
    chk("tie_stable", 32'(stable), 32'hF);
    step(1'b0, 1'b0);
    chk("tie_done", 32'(done), 32'h1);
    chk("tie_timeout", 32'(timeout), 32'h0);

    // Glitch on channel 0 after a long run, then recovery.
    rd_sel = 2'd0;
    step(1'b1, 1'b0);
    for (int i = 0; i < 26; i++) begin
      ch_data = pack4(32'h55, (i % 2 == 1) ? 32'h100 : 32'h0, 32'h66, 32'h77);
      step(1'b0, 1'b1);
    end
    chk("glitch_cnt25", 32'(rd_cnt), 32'd25);
    chk("glitch_st_pre", 32'(stable[0]), 32'h1);
    chk("glitch_st1", 32'(stable[1]), 32'h0);
    ch_data = pack4(32'h99, 32'h0, 32'h66, 32'h77);
    step(1'b0, 1'b1);
    chk("glitch_st_drop", 32'(stable[0]), 32'h0);
    chk("glitch_cnt0", 32'(rd_cnt), 32'd0);
    ch_data = pack4(32'h55, 32'h100, 32'h66, 32'h77);
    step(1'b0, 1'b1);
    chk("glitch_back_cnt", 32'(rd_cnt), 32'd0);
    for (int i = 0; i < 19; i++) begin
      ch_data = pack4(32'h55, (i % 2 == 1) ? 32'h100 : 32'h0, 32'h66, 32'h77);
      step(1'b0, 1'b1);
    end
    chk("recover_cnt19", 32'(rd_cnt), 32'd19);
    chk("recover_st_pre", 32'(stable[0]), 32'h0);
    ch_data = pack4(32'h55, 32'h100, 32'h66, 32'h77);
    step(1'b0, 1'b1);
    chk("recover_cnt20", 32'(rd_cnt), 32'd20);
    chk("recover_st", 32'(stable[0]), 32'h1);
    chk("recover_busy", 32'(busy), 32'h1);

    // Reset in the middle of a window.
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    chk("midrst_stable", 32'(stable), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_val", rd_value, 32'h0);
    chk("midrst_cnt", 32'(rd_cnt), 32'd0);
    ch_data = pack4(32'h12, 32'h12, 32'h12, 32'h12);
    step(1'b0, 1'b1);
    chk("idle_tick_val", rd_value, 32'h0);
    chk("idle_tick_busy", 32'(busy), 32'h0);

`ifdef STAB_TOLERANCE_EN
    // Tolerance 2: steps of 2 count as matches, steps of 3 do not.
    rd_sel = 2'd0;
    step(1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      ch_data = pack4((i % 2 == 1) ? 32'd102 : 32'd100, (i % 2 == 1) ? 32'd102 : 32'd100,
                      (i % 2 == 1) ? 32'd103 : 32'd100, (i % 2 == 1) ? 32'd102 : 32'd100);
      step(1'b0, 1'b1);
      if (i == 20) begin
        chk("tol_stable", 32'(stable), 32'hB);
        chk("tol_cnt20", 32'(rd_cnt), 32'd20);
      end
    end
    step(1'b0, 1'b1);
    chk("tol_done", 32'(done), 32'h1);
    chk("tol_timeout", 32'(timeout), 32'h1);
    chk("tol_stable_end", 32'(stable), 32'hB);
`endif

    // Three-channel instance: exact threshold, counter saturation, out-of-range readout.
    step_b(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      data_b = {8'h34, (i % 2 == 1) ? 8'h40 : 8'h00, 8'h12};
      step_b(1'b0, 1'b1);
    end
    chk("b_cnt4", 32'(cnt_b), 32'd4);
    chk("b_stable_pre", 32'(stable_b), 32'h0);
    data_b = {8'h34, 8'h00, 8'h12};
    step_b(1'b0, 1'b1);
    chk("b_stable", 32'(stable_b), 32'h5);
    for (int i = 0; i < 5; i++) begin
      data_b = {8'h34, (i % 2 == 1) ? 8'h00 : 8'h40, 8'h12};
      step_b(1'b0, 1'b1);
    end
    chk("b_sat_cnt", 32'(cnt_b), 32'd7);
    chk("b_sat_stable", 32'(stable_b), 32'h5);
    sel_b = 2'd3;
    #1;
    chk("b_oor_val", 32'(val_b), 32'h0);
    chk("b_oor_cnt", 32'(cnt_b), 32'h0);
    sel_b = 2'd2;
    #1;
    chk("b_sel2_val", 32'(val_b), 32'h34);
    chk("b_busy", 32'(busy_b), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
